div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq_pkg.sv | 9 +
 rtl/div_seq_addsuber.sv | 15 +
 rtl/div_seq.sv | 103 ++++++++++
 tb/tb_div_seq.sv | 128 ++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared state encoding and counter sizing for the sequential divider.
package div_seq_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
  localparam int DEFAULT_BITWIDTH = 32;
  function automatic int cnt_width(input int bw);
    return $clog2(bw) + 1;
  endfunction
  localparam int CNT_W = cnt_width(DEFAULT_BITWIDTH);
endpackage

// File: rtl/div_seq_addsuber.sv
// addsuber: W-bit adder/subtractor; carry_flag_o is carry-out on add and borrow on subtract.
module addsuber #(
  parameter int W = 33
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] y_o,
  output logic         carry_flag_o
);
  logic [W:0] sum;
  assign sum = {1'b0, a_i} + {1'b0, sub_i ? ~b_i : b_i} + {{W{1'b0}}, sub_i};
  assign y_o = sum[W-1:0];
  assign carry_flag_o = sub_i ? ~sum[W] : sum[W];
endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider (signed/unsigned, quotient/remainder) with valid/ready handshakes.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int BITWIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] dividend,
  input  logic [BITWIDTH-1:0] divisor,
  input  logic                is_signed,
  input  logic                want_rem,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] result
);
  localparam int W = BITWIDTH;
  localparam int CW = cnt_width(W);
  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0] dvd_q, dvs_q, quo_q, rem_q, result_q;
  logic sgn_q, rem_sel_q, qneg_q, rneg_q, in_ready_q, out_valid_q;
  logic [W:0] shifted_d, as_a, as_b, as_y;
  logic [W-1:0] fix_val_d;
  logic as_carry, fix_neg_d, dd_neg, ds_neg, ovf_d, unused_msb;
  always_comb begin
    shifted_d = {rem_q, dvd_q[W-1]};
    fix_val_d = rem_sel_q ? rem_q : quo_q;
    fix_neg_d = sgn_q & (rem_sel_q ? rneg_q : qneg_q);
    as_a = state_q == FIX ? '0 : shifted_d;
    as_b = {1'b0, state_q == FIX ? fix_val_d : dvs_q};
    dd_neg = is_signed & dividend[W-1];
    ds_neg = is_signed & divisor[W-1];
    ovf_d = is_signed & (dividend == {1'b1, {(W-1){1'b0}}}) & (&divisor);
  end
  // one unit serves both the trial subtraction and the final 0 - x negation
  addsuber #(.W(W + 1)) u_addsuber (
    .a_i(as_a), .b_i(as_b), .sub_i(1'b1), .y_o(as_y), .carry_flag_o(as_carry)
  );
  assign unused_msb = as_y[W];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      result_q <= '0;
      sgn_q <= 1'b0;
      rem_sel_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid && in_ready_q) begin
          sgn_q <= is_signed;
          rem_sel_q <= want_rem;
          qneg_q <= dividend[W-1] ^ divisor[W-1];
          rneg_q <= dividend[W-1];
          dvd_q <= dd_neg ? -dividend : dividend;
          dvs_q <= ds_neg ? -divisor : divisor;
          cnt_q <= CW'(W);
          quo_q <= '0;
          rem_q <= '0;
          in_ready_q <= 1'b0;
          if (divisor == '0 || ovf_d) begin
            state_q <= DONE;
            out_valid_q <= 1'b1;
            result_q <= divisor == '0 ? (want_rem ? dividend : '1) : (want_rem ? '0 : dividend);
          end else begin
            state_q <= CALC;
          end
        end
        CALC: begin
          rem_q <= as_carry ? shifted_d[W-1:0] : as_y[W-1:0];
          quo_q <= {quo_q[W-2:0], ~as_carry};
          dvd_q <= dvd_q << 1;
          cnt_q <= cnt_q - 1'b1;
          state_q <= cnt_q == CW'(1) ? FIX : CALC;
        end
        FIX: begin
          result_q <= fix_neg_d ? as_y[W-1:0] : fix_val_d;
          out_valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign result = result_q;
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed and random divisions checked against an arithmetic reference model.
module tb_div_seq;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, is_signed = 1'b0, want_rem = 1'b0;
  logic out_valid, out_ready = 1'b0;
  logic [31:0] dividend = '0, divisor = '0, result;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  div_seq #(.BITWIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .is_signed(is_signed), .want_rem(want_rem),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_div(input logic [31:0] dd, input logic [31:0] ds,
                                          input logic s, input logic r);
    int a, b;
    a = dd;
    b = ds;
    if (ds == 0) return r ? dd : 32'hFFFF_FFFF;
    if (s && dd == 32'h8000_0000 && ds == 32'hFFFF_FFFF) return r ? 32'h0 : dd;
    if (s) return r ? 32'(a % b) : 32'(a / b);
    return r ? dd % ds : dd / ds;
  endfunction
  function automatic int ref_lat(input logic [31:0] dd, input logic [31:0] ds, input logic s);
    return (ds == 0 || (s && dd == 32'h8000_0000 && ds == 32'hFFFF_FFFF)) ? 1 : 34;
  endfunction
  task automatic start_op(input logic [31:0] dd, input logic [31:0] ds, input logic s, input logic r);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk("idle_wait", 32'(in_ready), 32'd1);
    dividend = dd;
    divisor = ds;
    is_signed = s;
    want_rem = r;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
    is_signed = ~s;
    want_rem = ~r;
  endtask
  task automatic run_op(input string tag, input logic [31:0] dd, input logic [31:0] ds,
                        input logic s, input logic r, input int hold);
    int n;
    logic [31:0] exp;
    exp = ref_div(dd, ds, s, r);
    start_op(dd, ds, s, r);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    chk({tag, "_lat"}, 32'(n), 32'(ref_lat(dd, ds, s)));
    chk({tag, "_res"}, result, exp);
    in_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_res"}, result, exp);
      chk({tag, "_hold_ov"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_ir"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_post_ir"}, 32'(in_ready), 32'd1);
    chk({tag, "_post_ov"}, 32'(out_valid), 32'd0);
  endtask
  initial begin
    logic [31:0] dd, ds;
    logic s;
    repeat (2) @(negedge clk);
    chk("rst_ir", 32'(in_ready), 32'd1);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_res", result, 32'd0);
    rst = 1'b0;
    run_op("u100d7q", 32'd100, 32'd7, 1'b0, 1'b0, 0);
    run_op("u100d7r", 32'd100, 32'd7, 1'b0, 1'b1, 0);
    run_op("sm7d2q", -32'sd7, 32'd2, 1'b1, 1'b0, 0);
    run_op("sm7d2r", -32'sd7, 32'd2, 1'b1, 1'b1, 0);
    run_op("u5d0q", 32'd5, 32'd0, 1'b0, 1'b0, 0);
    run_op("u5d0r", 32'd5, 32'd0, 1'b0, 1'b1, 0);
    run_op("ovfq", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
    run_op("ovfr", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 0);
    run_op("hold10", 32'd1000, 32'd33, 1'b0, 1'b0, 10);
    run_op("umaxd1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1);
    run_op("sneg_neg", -32'sd100, -32'sd7, 1'b1, 1'b1, 0);
    start_op(32'h1234_5678, 32'd7, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("calc_rst_ov", 32'(out_valid), 32'd0);
    chk("calc_rst_ir", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b0, 0);
    for (int k = 0; k < 40; k++) begin
      s = 1'($urandom);
      dd = $urandom;
      case ($urandom_range(0, 5))
        0: ds = 32'($urandom_range(1, 15));
        1: ds = 32'd0;
        2: begin dd = 32'h8000_0000; ds = 32'hFFFF_FFFF; end
        3: ds = -32'($urandom_range(1, 1000));
        default: ds = $urandom >> $urandom_range(0, 31);
      endcase
      run_op("rand", dd, ds, s, 1'($urandom), $urandom_range(0, 3));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
